// File: rtl/par_check_sink_pkg.sv
// rtl/par_check_sink_pkg.sv - shared packet layout, widths and helpers for par_check_sink
package par_check_sink_pkg;

    localparam int HDR_SZ    = 4;
    localparam int PL_SZ     = 16;
    localparam int ADDR_SZ   = 4;
    localparam int NUM_NODES = 9;

    // src/seq placement inside the payload, shared with par_source_from_memory
    localparam int SEQ_SZ  = 8;
    localparam int SEQ_LSB = 0;
    localparam int SRC_LSB = SEQ_LSB + SEQ_SZ;

    localparam int DATA_SZ    = HDR_SZ + PL_SZ + ADDR_SZ;
    localparam int RX_CNT_SZ  = 20;
    localparam int ERR_CNT_SZ = 16;

    typedef struct packed {
        logic [HDR_SZ-1:0]  hdr;
        logic [PL_SZ-1:0]   payload;
        logic [ADDR_SZ-1:0] dest;
    } packet_t;

    function automatic logic [SEQ_SZ-1:0] pkt_seq(input packet_t p);
        return p.payload[SEQ_LSB +: SEQ_SZ];
    endfunction

    function automatic logic [ADDR_SZ-1:0] pkt_src(input packet_t p);
        return p.payload[SRC_LSB +: ADDR_SZ];
    endfunction

    function automatic logic addr_ok(input logic [ADDR_SZ-1:0] dest,
                                     input logic [ADDR_SZ-1:0] src,
                                     input logic [ADDR_SZ-1:0] id);
        return (dest == id) && (int'(src) < NUM_NODES);
    endfunction

endpackage

// File: rtl/par_check_sink_if.sv
// rtl/par_check_sink_if.sv - router local-output flit port (data/valid with busy back-pressure)
interface par_check_sink_if;
    import par_check_sink_pkg::*;

    logic [DATA_SZ-1:0] data;
    logic               valid;
    logic               busy;

    modport master (output data, output valid, input busy);
    modport slave  (input data, input valid, output busy);

endinterface

// File: rtl/par_check_sink_lfsr8.sv
// rtl/par_check_sink_lfsr8.sv - 8-bit Fibonacci LFSR (taps 8,6,5,4) used by the moody sinks
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] state
);

    logic feedback;

    assign feedback = state[7] ^ state[5] ^ state[4] ^ state[3];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[6:0], feedback};
        end
    end

endmodule

// File: rtl/par_check_sink.sv
// rtl/par_check_sink.sv - NoC checking sink with LFSR back-pressure; SINK_SEQ_CHECK_EN adds per-source sequence checking
module par_check_sink
    import par_check_sink_pkg::*;
#(
    parameter int unsigned ID        = 0,
    parameter int unsigned SINK_HOSP = 255,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    par_check_sink_if.slave       rx,
    output logic [RX_CNT_SZ-1:0]  rx_count,
    output logic [ERR_CNT_SZ-1:0] err_addr_count,
    output logic [ERR_CNT_SZ-1:0] err_seq_count,
    output logic                  err_flag
);

    localparam logic [ADDR_SZ-1:0] ID_ADDR = ADDR_SZ'(ID);
    localparam logic [7:0]         HOSP    = 8'(SINK_HOSP);

    logic [7:0]         lfsr;
    logic               busy;
    logic               acc;
    logic               addr_err;
    logic               seq_err;
    packet_t            pkt;
    logic [ADDR_SZ-1:0] src;
    logic [SEQ_SZ-1:0]  seq;

    assign pkt = rx.data;
    assign src = pkt_src(pkt);
    assign seq = pkt_seq(pkt);

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .state (lfsr)
    );

    // Busy is registered from the current LFSR value, so it reads 1 for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= 1'b1;
        end else begin
            busy <= (lfsr > HOSP);
        end
    end

    assign rx.busy  = busy;
    assign acc      = rx.valid & ~busy;
    assign addr_err = ~addr_ok(pkt.dest, src, ID_ADDR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_count       <= '0;
            err_addr_count <= '0;
            err_flag       <= 1'b0;
        end else if (acc) begin
            if (rx_count != '1) begin
                rx_count <= rx_count + 1'b1;
            end
            if (addr_err && (err_addr_count != '1)) begin
                err_addr_count <= err_addr_count + 1'b1;
            end
            if (addr_err || seq_err) begin
                err_flag <= 1'b1;
            end
        end
    end

`ifdef SINK_SEQ_CHECK_EN
    logic [SEQ_SZ-1:0] exp_seq [NUM_NODES];
    logic [SEQ_SZ-1:0] exp_cur;

    always_comb begin
        exp_cur = '0;
        for (int n = 0; n < NUM_NODES; n++) begin
            if (src == ADDR_SZ'(n)) begin
                exp_cur = exp_seq[n];
            end
        end
    end

    assign seq_err = ~addr_err & (seq != exp_cur);

    // Resynchronise on every in-range packet, good or bad, so one gap costs one error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                exp_seq[n] <= '0;
            end
        end else if (acc && !addr_err) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                if (src == ADDR_SZ'(n)) begin
                    exp_seq[n] <= seq + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_seq_count <= '0;
        end else if (acc && seq_err && (err_seq_count != '1)) begin
            err_seq_count <= err_seq_count + 1'b1;
        end
    end
`else
    logic unused_seq;

    assign seq_err       = 1'b0;
    assign err_seq_count = '0;
    assign unused_seq    = ^seq;
`endif

    logic unused_fields;
    assign unused_fields = ^{pkt.hdr, pkt.payload[PL_SZ-1:SRC_LSB+ADDR_SZ]};

endmodule

// File: tb/tb_par_check_sink.sv
// tb/tb_par_check_sink.sv - scoreboard bench for par_check_sink
module tb_par_check_sink;
    import par_check_sink_pkg::*;

    localparam int         SINK_ID   = 4;
    localparam int         BP_HOSP   = 64;
    localparam logic [7:0] SEED      = 8'hA5;
    localparam int         BP_CYCLES = 4096;
`ifdef SINK_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    typedef struct {
        int rx;
        int ea;
        int es;
        int flag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    logic [RX_CNT_SZ-1:0]  rx_a, rx_b;
    logic [ERR_CNT_SZ-1:0] ea_a, es_a, ea_b, es_b;
    logic                  ef_a, ef_b;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    int   m_rx, m_ea, m_es, m_flag;
    int   m_exp[NUM_NODES];
    int   b_acc = 0;

    par_check_sink_if if_a ();
    par_check_sink_if if_b ();

    always #5 clk = ~clk;

    par_check_sink #(.ID(SINK_ID), .SINK_HOSP(255), .LFSR_SEED(SEED)) dut_a (
        .clk            (clk),
        .reset          (rst_a),
        .rx             (if_a),
        .rx_count       (rx_a),
        .err_addr_count (ea_a),
        .err_seq_count  (es_a),
        .err_flag       (ef_a)
    );

    par_check_sink #(.ID(SINK_ID), .SINK_HOSP(BP_HOSP), .LFSR_SEED(SEED)) dut_b (
        .clk            (clk),
        .reset          (rst_b),
        .rx             (if_b),
        .rx_count       (rx_b),
        .err_addr_count (ea_b),
        .err_seq_count  (es_b),
        .err_flag       (ef_b)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_rx = 0; m_ea = 0; m_es = 0; m_flag = 0;
        foreach (m_exp[i]) m_exp[i] = 0;
    endfunction

    function automatic void model_accept(input int dest, input int src, input int seq);
        exp_t e;
        if (m_rx < 1048575) m_rx++;
        if (dest != SINK_ID || src >= NUM_NODES) begin
            if (m_ea < 65535) m_ea++;
            m_flag = 1;
        end else begin
            if (SEQ_EN && seq != m_exp[src]) begin
                if (m_es < 65535) m_es++;
                m_flag = 1;
            end
            m_exp[src] = (seq + 1) % 256;
        end
        e.rx = m_rx; e.ea = m_ea; e.es = m_es; e.flag = m_flag;
        sb_q.push_back(e);
    endfunction

    function automatic logic [DATA_SZ-1:0] make_data(input int dest, input int src, input int seq);
        logic [PL_SZ-1:0] pl;
        pl = PL_SZ'($urandom);
        pl[SEQ_LSB +: SEQ_SZ]  = SEQ_SZ'(seq);
        pl[SRC_LSB +: ADDR_SZ] = ADDR_SZ'(src);
        return {HDR_SZ'($urandom), pl, ADDR_SZ'(dest)};
    endfunction

    function automatic int lfsr_next(input int x);
        int fb;
        fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
        return ((x << 1) | fb) & 255;
    endfunction

    task automatic send_a(input int dest, input int src, input int seq);
        if_a.data  = make_data(dest, src, seq);
        if_a.valid = 1'b1;
        model_accept(dest, src, seq);
        @(negedge clk);
    endtask

    task automatic idle_a(input int n);
        if_a.valid = 1'b0;
        if_a.data  = DATA_SZ'($urandom);
        repeat (n) @(negedge clk);
    endtask

    initial begin : mon_a
        bit   acc;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            acc = rst_a && if_a.valid && !if_a.busy;
            @(posedge clk);
            #1;
            if (acc) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: rx_count=%0d, no packet expected", rx_a);
                end else begin
                    e = sb_q.pop_front();
                    check("rx_count", int'(rx_a), e.rx);
                    check("err_addr_count", int'(ea_a), e.ea);
                    check("err_seq_count", int'(es_a), e.es);
                    check("err_flag", int'(ef_a), e.flag);
                end
            end
        end
    end

    initial begin : mon_b
        int lf;
        int bm;
        lf = int'(SEED);
        bm = 1;
        forever begin
            @(posedge clk);
            if (!rst_b) begin
                lf = int'(SEED);
                bm = 1;
            end else begin
                if (if_b.valid && bm == 0) b_acc++;
                bm = (lf > BP_HOSP) ? 1 : 0;
                lf = lfsr_next(lf);
            end
            @(negedge clk);
            check("busy_b", int'(if_b.busy), bm);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        if_a.valid = 1'b0;
        if_a.data  = '0;
        if_b.valid = 1'b0;
        if_b.data  = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset_busy_a", int'(if_a.busy), 1);
        check("reset_busy_b", int'(if_b.busy), 1);
        check("reset_rx_a", int'(rx_a), 0);
        check("reset_ea_a", int'(ea_a), 0);
        check("reset_es_a", int'(es_a), 0);
        check("reset_flag_a", int'(ef_a), 0);
        check("reset_rx_b", int'(rx_b), 0);

        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check("busy_a_release_cycle", int'(if_a.busy), 1);
        @(negedge clk);
        check("busy_a_after_release", int'(if_a.busy), 0);

        for (int i = 0; i < 300; i++) send_a(SINK_ID, 2, i % 256);
        idle_a(2);

        send_a(SINK_ID, 1, 0);
        send_a(SINK_ID, 1, 1);
        send_a(SINK_ID, 1, 3);
        send_a(SINK_ID, 1, 4);
        idle_a(2);

        send_a(5, 2, 44);
        send_a(SINK_ID, 9, 0);
        send_a(SINK_ID, 2, 44);
        idle_a(2);

        for (int i = 0; i < 400; i++) begin
            int src, dest, seq;
            src  = $urandom_range(0, 10);
            dest = ($urandom_range(0, 9) == 0) ? 5 : SINK_ID;
            if (src < NUM_NODES && $urandom_range(0, 7) != 0) seq = m_exp[src];
            else seq = $urandom_range(0, 255);
            send_a(dest, src, seq);
            if ($urandom_range(0, 3) == 0) idle_a($urandom_range(1, 3));
        end
        idle_a(3);
        check("scoreboard_drained_1", sb_q.size(), 0);

        for (int i = 0; i < 10; i++) send_a(SINK_ID, 1, m_exp[1]);
        if_a.data  = make_data(SINK_ID, 1, m_exp[1]);
        if_a.valid = 1'b1;
        rst_a      = 1'b0;
        model_reset();
        @(negedge clk);
        if_a.valid = 1'b0;
        @(negedge clk);
        check("midreset_rx_a", int'(rx_a), 0);
        check("midreset_flag_a", int'(ef_a), 0);
        check("midreset_busy_a", int'(if_a.busy), 1);
        rst_a = 1'b1;
        @(negedge clk);
        send_a(SINK_ID, 1, 0);
        idle_a(3);
        check("scoreboard_drained_2", sb_q.size(), 0);

        if_b.data  = make_data(SINK_ID, 0, 0);
        if_b.valid = 1'b1;
        repeat (BP_CYCLES) @(negedge clk);
        if_b.valid = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_rx_count", int'(rx_b), b_acc);
        check("bp_err_addr", int'(ea_b), 0);
        check("bp_err_seq", int'(es_b), (SEQ_EN && b_acc > 0) ? b_acc - 1 : 0);
        check("bp_err_flag", int'(ef_b), (SEQ_EN && b_acc > 1) ? 1 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
